m_multicycle_ctrl: RTL and testbench

Moore-style control FSM that sequences a multi-cycle RV32 datapath. In that datapath the ALU, a single shared instruction/data memory and the register file are reused across several cycles per instruction. The block sits beside the datapath and reads the instruction-register fields and the ALU zero flag. It drives every write enable, mux select and ALU operation code, and stalls on a memory ready handshake.

---
 rtl/m_multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_m_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_multicycle_ctrl.sv
// m_multicycle_ctrl -- control FSM for a multi-cycle RV32 datapath.
// Drives the write enables, mux selects and ALU op for a shared-memory
// multi-cycle core. It stalls in the memory states until w_mem_rdy is seen.
// Optional build macro: MC_CTRL_PERF_EN adds the w_cycle_cnt / w_instret counters.
//
// state    | code | meaning
// ---------+------+---------------------------------------------------
// FETCH    |  0   | read instr at PC, PC <= PC+4 and IR load on mem_rdy
// DECODE   |  1   | ALUOut <= oldPC + imm (branch/jump target)
// MEMADR   |  2   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  |  3   | read data memory at ALUOut until mem_rdy
// MEMWB    |  4   | rd <= memory data register
// MEMWRITE |  5   | write rs2 to memory at ALUOut until mem_rdy
// EXECR    |  6   | ALUOut <= rs1 op rs2
// EXECI    |  7   | ALUOut <= rs1 op imm
// ALUWB    |  8   | rd <= ALUOut
// BRANCH   |  9   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | 10   | PC <= ALUOut, ALUOut <= oldPC + 4 (link)
// LUI      | 11   | ALUOut <= imm
// TRAP     | 15   | illegal opcode, parked until reset

module m_multicycle_ctrl (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_mem_rdy,
    input  logic [6:0] w_opcode,
    input  logic [2:0] w_funct3,
    input  logic       w_funct7_5,
    input  logic       w_alu_zero,
    output logic       w_pc_we,
    output logic       w_ir_we,
    output logic       w_adr_src,
    output logic       w_mem_we,
    output logic       w_reg_we,
    output logic [1:0] w_alu_src_a,
    output logic [1:0] w_alu_src_b,
    output logic [1:0] w_result_src,
    output logic [2:0] w_alu_control,
    output logic [3:0] w_state,
    output logic       w_trap
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] w_cycle_cnt,
    output logic [31:0] w_instret
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    state_t state;
    state_t state_nxt;

    // funct3 -> ALU op; funct7[5] only selects sub for register-register ops
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
        logic [2:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = w_mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_opcode)
                    7'b0000011,
                    7'b0100011: state_nxt = S_MEMADR;
                    7'b0110011: state_nxt = S_EXECR;
                    7'b0010011: state_nxt = S_EXECI;
                    7'b1100011: state_nxt = S_BRANCH;
                    7'b1101111: state_nxt = S_JAL;
                    7'b0110111: state_nxt = S_LUI;
                    default:    state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   state_nxt = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nxt = w_mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = w_mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_LUI:      state_nxt = S_ALUWB;
            S_TRAP:     state_nxt = S_TRAP;
            // unused codes 12..14 recover to FETCH
            default:    state_nxt = S_FETCH;
        endcase
    end

    // state register
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Moore output decode; enables are masked while reset is held so that
    // FETCH's ready-driven IR/PC load cannot fire during reset
    always_comb begin
        w_pc_we       = 1'b0;
        w_ir_we       = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_we      = 1'b0;
        w_reg_we      = 1'b0;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_alu_control = ALU_ADD;
        w_trap        = 1'b0;
        case (state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_we      = w_mem_rdy;
                w_pc_we      = w_mem_rdy;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_we     = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src = 1'b1;
                w_mem_we  = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = alu_dec(w_funct3, w_funct7_5);
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = alu_dec(w_funct3, 1'b0);
            end
            S_ALUWB: begin
                w_reg_we = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                case (w_funct3)
                    3'b000:  w_pc_we = w_alu_zero;
                    3'b001:  w_pc_we = ~w_alu_zero;
                    default: w_pc_we = 1'b0;
                endcase
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_we     = 1'b1;
            end
            S_LUI: begin
                w_alu_src_b   = 2'b01;
                w_alu_control = ALU_PASS;
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: begin
                w_trap = 1'b0;
            end
        endcase
        if (w_rst) begin
            w_pc_we  = 1'b0;
            w_ir_we  = 1'b0;
            w_mem_we = 1'b0;
            w_reg_we = 1'b0;
            w_trap   = 1'b0;
        end
    end

    assign w_state = state;

`ifdef MC_CTRL_PERF_EN
    // cycle and retired-instruction counters, free-running modulo 2^32
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_cycle_cnt <= 32'd0;
            w_instret   <= 32'd0;
        end else begin
            if (state != S_TRAP) begin
                w_cycle_cnt <= w_cycle_cnt + 32'd1;
            end
            if ((state_nxt == S_FETCH) && (state != S_FETCH)) begin
                w_instret <= w_instret + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Bench for m_multicycle_ctrl: per-cycle expected output vectors are queued
// with their stimulus, then replayed and compared one cycle at a time.
module tb_m_multicycle_ctrl;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        w_mem_rdy;
    logic [31:0] ir;
    logic        w_alu_zero;
    logic        w_pc_we, w_ir_we, w_adr_src, w_mem_we, w_reg_we, w_trap;
    logic [1:0]  w_alu_src_a, w_alu_src_b, w_result_src;
    logic [2:0]  w_alu_control;
    logic [3:0]  w_state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] w_cycle_cnt, w_instret;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 w_clk = ~w_clk;

    m_multicycle_ctrl dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .w_mem_rdy    (w_mem_rdy),
        .w_opcode     (ir[6:0]),
        .w_funct3     (ir[14:12]),
        .w_funct7_5   (ir[30]),
        .w_alu_zero   (w_alu_zero),
        .w_pc_we      (w_pc_we),
        .w_ir_we      (w_ir_we),
        .w_adr_src    (w_adr_src),
        .w_mem_we     (w_mem_we),
        .w_reg_we     (w_reg_we),
        .w_alu_src_a  (w_alu_src_a),
        .w_alu_src_b  (w_alu_src_b),
        .w_result_src (w_result_src),
        .w_alu_control(w_alu_control),
        .w_state      (w_state),
        .w_trap       (w_trap)
`ifdef MC_CTRL_PERF_EN
        ,
        .w_cycle_cnt  (w_cycle_cnt),
        .w_instret    (w_instret)
`endif
    );

    // {state, pc_we, ir_we, adr_src, mem_we, reg_we, a, b, result, alu, trap}
    logic [31:0] dut_v;
    assign dut_v = {13'd0, w_state, w_pc_we, w_ir_we, w_adr_src, w_mem_we, w_reg_we,
                    w_alu_src_a, w_alu_src_b, w_result_src, w_alu_control, w_trap};

    typedef struct {
        string       tag;
        logic [31:0] ir;
        logic        rdy;
        logic        zero;
        logic [31:0] exp;
    } rec_t;

    rec_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%05h want 0x%05h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] st, input logic [4:0] en,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [2:0] alu,
                                       input logic trap);
        return {13'd0, st, en, a, b, rs, alu, trap};
    endfunction

    // en = {pc_we, ir_we, adr_src, mem_we, reg_we}
    function automatic logic [31:0] e_fetch(input logic r);
        return ev(4'd0, {r, r, 3'b000}, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_decode();
        return ev(4'd1, 5'b00000, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_memadr();
        return ev(4'd2, 5'b00000, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_memrd();
        return ev(4'd3, 5'b00100, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_memwb();
        return ev(4'd4, 5'b00001, 2'd0, 2'd0, 2'd1, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_memwr();
        return ev(4'd5, 5'b00110, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_execr(input logic [2:0] alu);
        return ev(4'd6, 5'b00000, 2'd2, 2'd0, 2'd0, alu, 1'b0);
    endfunction
    function automatic logic [31:0] e_execi(input logic [2:0] alu);
        return ev(4'd7, 5'b00000, 2'd2, 2'd1, 2'd0, alu, 1'b0);
    endfunction
    function automatic logic [31:0] e_aluwb();
        return ev(4'd8, 5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_branch(input logic p);
        return ev(4'd9, {p, 4'b0000}, 2'd2, 2'd0, 2'd0, 3'd1, 1'b0);
    endfunction
    function automatic logic [31:0] e_jal();
        return ev(4'd10, 5'b10000, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0);
    endfunction
    function automatic logic [31:0] e_lui();
        return ev(4'd11, 5'b00000, 2'd0, 2'd1, 2'd0, 3'd4, 1'b0);
    endfunction
    function automatic logic [31:0] e_trap();
        return ev(4'd15, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1);
    endfunction

    task automatic push(input string tag, input logic [31:0] i, input logic r,
                        input logic z, input logic [31:0] e);
        rec_t x;
        x.tag = tag; x.ir = i; x.rdy = r; x.zero = z; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic push_r(input string t, input logic [31:0] i, input logic [2:0] alu);
        push(t, i, 1'b1, 1'b0, e_fetch(1'b1));
        push(t, i, 1'b1, 1'b0, e_decode());
        push(t, i, 1'b1, 1'b0, e_execr(alu));
        push(t, i, 1'b1, 1'b0, e_aluwb());
    endtask

    task automatic push_i(input string t, input logic [31:0] i, input logic [2:0] alu);
        push(t, i, 1'b1, 1'b0, e_fetch(1'b1));
        push(t, i, 1'b1, 1'b0, e_decode());
        push(t, i, 1'b1, 1'b0, e_execi(alu));
        push(t, i, 1'b1, 1'b0, e_aluwb());
    endtask

    // lw with a number of not-ready cycles in MEMREAD
    task automatic push_lw(input string t, input int stall);
        logic [31:0] i;
        i = 32'h0000A183;
        push(t, i, 1'b1, 1'b0, e_fetch(1'b1));
        push(t, i, 1'b1, 1'b0, e_decode());
        push(t, i, 1'b1, 1'b0, e_memadr());
        for (int k = 0; k < stall; k++) push(t, i, 1'b0, 1'b0, e_memrd());
        push(t, i, 1'b1, 1'b0, e_memrd());
        push(t, i, 1'b1, 1'b0, e_memwb());
    endtask

    task automatic push_br(input string t, input logic [31:0] i, input logic z, input logic taken);
        push(t, i, 1'b1, z, e_fetch(1'b1));
        push(t, i, 1'b1, z, e_decode());
        push(t, i, 1'b1, z, e_branch(taken));
    endtask

    task automatic run_q();
        rec_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            ir = r.ir;
            w_mem_rdy = r.rdy;
            w_alu_zero = r.zero;
            #1;
            check_eq(r.tag, dut_v, r.exp);
            @(negedge w_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        w_rst = 1'b1;
        ir = 32'h0;
        w_mem_rdy = 1'b1;
        w_alu_zero = 1'b0;
        #2;
        check_eq("reset_hold", dut_v, e_fetch(1'b0));
        @(negedge w_clk);
        @(negedge w_clk);
        check_eq("reset_hold2", dut_v, e_fetch(1'b0));
        w_rst = 1'b0;
`ifdef MC_CTRL_PERF_EN
        check_eq("instret_rst", w_instret, 32'd0);
`endif

        push_r("add", 32'h002081B3, 3'b000);
        push_lw("lw_nostall", 0);
        run_q();
`ifdef MC_CTRL_PERF_EN
        #1;
        check_eq("instret", w_instret, 32'd2);
        check_eq("cycle_cnt", w_cycle_cnt, 32'd9);
`endif

        push_r("sub", 32'h402081B3, 3'b001);
        push_i("addi_b30", 32'h40008093, 3'b000);
        push_r("slt", 32'h0020A1B3, 3'b101);
        push_r("or", 32'h0020E1B3, 3'b011);
        push_r("and", 32'h0020F1B3, 3'b010);
        push_r("xor_add", 32'h0020C1B3, 3'b000);
        push("fetch_stall", 32'h0000A183, 1'b0, 1'b0, e_fetch(1'b0));
        push_lw("lw_stall2", 2);
        push("sw", 32'h0020A023, 1'b1, 1'b0, e_fetch(1'b1));
        push("sw", 32'h0020A023, 1'b1, 1'b0, e_decode());
        push("sw", 32'h0020A023, 1'b1, 1'b0, e_memadr());
        push("sw_wait", 32'h0020A023, 1'b0, 1'b0, e_memwr());
        push("sw_done", 32'h0020A023, 1'b1, 1'b0, e_memwr());
        push_br("beq_z1", 32'h00208463, 1'b1, 1'b1);
        push_br("beq_z0", 32'h00208463, 1'b0, 1'b0);
        push_br("bne_z1", 32'h00209463, 1'b1, 1'b0);
        push_br("bne_z0", 32'h00209463, 1'b0, 1'b1);
        push_br("blt_none", 32'h0020C463, 1'b1, 1'b0);
        push("jal", 32'h0000006F, 1'b1, 1'b0, e_fetch(1'b1));
        push("jal", 32'h0000006F, 1'b1, 1'b0, e_decode());
        push("jal", 32'h0000006F, 1'b1, 1'b0, e_jal());
        push("jal_wb", 32'h0000006F, 1'b1, 1'b0, e_aluwb());
        push("lui", 32'h000010B7, 1'b1, 1'b0, e_fetch(1'b1));
        push("lui", 32'h000010B7, 1'b1, 1'b0, e_decode());
        push("lui", 32'h000010B7, 1'b1, 1'b0, e_lui());
        push("lui_wb", 32'h000010B7, 1'b1, 1'b0, e_aluwb());
        push("trap", 32'h0000007F, 1'b1, 1'b0, e_fetch(1'b1));
        push("trap", 32'h0000007F, 1'b1, 1'b0, e_decode());
        for (int k = 0; k < 3; k++) push("trap_hold", 32'h0000007F, 1'b1, 1'b0, e_trap());
        run_q();

        // asynchronous reset mid-cycle, well away from the next rising edge
        #3;
        w_rst = 1'b1;
        #1;
        check_eq("async_rst", dut_v, e_fetch(1'b0));
        @(negedge w_clk);
        w_rst = 1'b0;

        push_r("add_after_rst", 32'h002081B3, 3'b000);
        push("final_fetch", 32'h002081B3, 1'b1, 1'b0, e_fetch(1'b1));
        run_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
